button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button conditioner for a two-button up/down counter front end.
// Each raw button is synchronized, debounced, and then turned into
// one-cycle event pulses: one on press, one after REPEAT_DELAY, then one
// every REPEAT_PERIOD while held. A button's events are suppressed while
// the other button is held, so increment and decrement never coincide.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1250000,
   parameter int unsigned REPEAT_DELAY    = 62500000,
   parameter int unsigned REPEAT_PERIOD   = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       BTN0,
   input  logic       BTN1,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic [1:0] btn_level
);

   localparam int unsigned TIMER_MAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW = (TIMER_MAX < 1) ? 1 : $clog2(TIMER_MAX + 1);
   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_DELAY = TW'(REPEAT_DELAY);
   localparam logic [TW-1:0] TIMER_PER   = TW'(REPEAT_PERIOD);
   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      HOLD     = 2'd1,
      REPEAT   = 2'd2
   } state_t;

   logic [1:0] rawBtn;
   logic [1:0] levelVec;
   logic [1:0] eventVec;
   logic       incPulse_q, incPulse_d;
   logic       decPulse_q, decPulse_d;

   assign rawBtn = {BTN1, BTN0};

   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic          sync1_q, sync2_q;
      logic          level_q, level_d;
      logic [CW-1:0] cnt_q, cnt_d;
      state_t        state_q, state_d;
      logic [TW-1:0] timer_q, timer_d;
      logic          event_d;

      // Two-flop synchronizer for the asynchronous raw button.
      always_ff @(posedge clk) begin
         if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
         end else begin
            sync1_q <= rawBtn[b];
            sync2_q <= sync1_q;
         end
      end

      // Debounce: count cycles of disagreement and flip the level once the run is long enough.
      always_comb begin
         level_d = level_q;
         cnt_d   = '0;
         if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
               level_d = ~level_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      // Debounced level and disagreement counter registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
         end
      end

      // Press / hold / auto-repeat sequencing; a timer value of one means it expires at this edge.
      always_comb begin
         state_d = state_q;
         event_d = 1'b0;
         timer_d = (timer_q != '0) ? (timer_q - 1'b1) : '0;
         case (state_q)
            RELEASED: begin
               if (level_q) begin
                  event_d = 1'b1;
                  timer_d = TIMER_DELAY;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (!level_q) begin
                  state_d = RELEASED;
                  timer_d = '0;
               end else if (timer_q == TIMER_ONE) begin
                  event_d = 1'b1;
                  timer_d = TIMER_PER;
                  state_d = REPEAT;
               end
            end
            REPEAT: begin
               if (!level_q) begin
                  state_d = RELEASED;
                  timer_d = '0;
               end else if (timer_q == TIMER_ONE) begin
                  event_d = 1'b1;
                  timer_d = TIMER_PER;
               end
            end
            default: begin
               state_d = RELEASED;
               timer_d = '0;
            end
         endcase
      end

      // FSM state and repeat timer registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= RELEASED;
            timer_q <= '0;
         end else begin
            state_q <= state_d;
            timer_q <= timer_d;
         end
      end

      assign levelVec[b] = level_q;
      assign eventVec[b] = event_d;
   end

   // Conflict gating: an event only becomes a pulse while the other button is released.
   always_comb begin
      incPulse_d = eventVec[0] & ~levelVec[1];
      decPulse_d = eventVec[1] & ~levelVec[0];
   end

   // Registered one-cycle output pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         incPulse_q <= 1'b0;
         decPulse_q <= 1'b0;
      end else begin
         incPulse_q <= incPulse_d;
         decPulse_q <= decPulse_d;
      end
   end

   assign inc_pulse = incPulse_q;
   assign dec_pulse = decPulse_q;
   assign btn_level = levelVec;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with a press-time based reference model.
module tb_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       BTN0;
   logic       BTN1;
   logic       inc_pulse;
   logic       dec_pulse;
   logic [1:0] btn_level;

   int checks   = 0;
   int failures = 0;

   // Reference model state: two-stage input delay, debounced levels,
   // disagreement run lengths, and the edge at which each press began.
   logic [1:0] mSync1, mSync2, mLevel, mActive;
   int         mRun[2];
   int         mPress[2];
   int         edgeNum = 0;
   logic       expInc, expDec;

   int   incSeen, decSeen;
   logic lvl1Seen;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .BTN0(BTN0),
      .BTN1(BTN1),
      .inc_pulse(inc_pulse),
      .dec_pulse(dec_pulse),
      .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edgeNum, observed, expected);
      end
   endtask

   // Model one rising edge: events from the pre-edge levels, then debounce, then input delay.
   task automatic modelEdge(input logic r, input logic [1:0] raw);
      logic [1:0] ev;
      int held;
      edgeNum++;
      if (r) begin
         mSync1  = '0;
         mSync2  = '0;
         mLevel  = '0;
         mActive = '0;
         mRun[0] = 0;
         mRun[1] = 0;
         expInc  = 1'b0;
         expDec  = 1'b0;
         return;
      end
      ev = '0;
      for (int b = 0; b < 2; b++) begin
         if (!mActive[b]) begin
            if (mLevel[b]) begin
               ev[b]      = 1'b1;
               mActive[b] = 1'b1;
               mPress[b]  = edgeNum;
            end
         end else if (!mLevel[b]) begin
            mActive[b] = 1'b0;
         end else begin
            held = edgeNum - mPress[b];
            if (held == RD || (held > RD && ((held - RD) % RP) == 0))
               ev[b] = 1'b1;
         end
      end
      expInc = ev[0] && !mLevel[1];
      expDec = ev[1] && !mLevel[0];
      for (int b = 0; b < 2; b++) begin
         if (mSync2[b] != mLevel[b]) begin
            mRun[b]++;
            if (mRun[b] == DB) begin
               mLevel[b] = ~mLevel[b];
               mRun[b]   = 0;
            end
         end else begin
            mRun[b] = 0;
         end
      end
      mSync2 = mSync1;
      mSync1 = raw;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare just after it.
   task automatic applyStimulus(input logic r, input logic b0, input logic b1);
      reset = r;
      BTN0  = b0;
      BTN1  = b1;
      @(posedge clk);
      modelEdge(r, {b1, b0});
      #1;
      checkOutput("inc_pulse", int'(inc_pulse), int'(expInc));
      checkOutput("dec_pulse", int'(dec_pulse), int'(expDec));
      checkOutput("btn_level", int'(btn_level), int'(mLevel));
      checkOutput("exclusive", int'(inc_pulse & dec_pulse), 0);
      incSeen  += int'(inc_pulse);
      decSeen  += int'(dec_pulse);
      lvl1Seen |= btn_level[1];
   endtask

   initial begin
      int firstInc;
      int lvl0At;
      logic [1:0] tgt;
      int remain[2];
      reset = 1'b1;
      BTN0  = 1'b0;
      BTN1  = 1'b0;

      // Reset state
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("reset_level", int'(btn_level), 0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);

      // Clean press: first inc after edge 7, level after edge 6
      incSeen = 0; decSeen = 0; firstInc = 0; lvl0At = 0;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (inc_pulse && firstInc == 0) firstInc = k;
         if (btn_level[0] && lvl0At == 0) lvl0At = k;
      end
      for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("clean_first_inc", firstInc, 7);
      checkOutput("clean_level_edge", lvl0At, 6);
      checkOutput("clean_inc_count", incSeen, 1);
      checkOutput("clean_dec_count", decSeen, 0);

      // Bounce on BTN1 shorter than the debounce window
      decSeen = 0; lvl1Seen = 1'b0;
      for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, ((k / 2) % 2) == 0);
      for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bounce_dec_count", decSeen, 0);
      checkOutput("bounce_level1", int'(lvl1Seen), 0);

      // Auto-repeat: pulses after edges 7,27,32,...,62
      incSeen = 0;
      for (int k = 0; k < 60; k++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("repeat_inc_count", incSeen, 9);

      // Conflict: BTN1 joins BTN0 and later releases
      for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset mid-repeat with BTN0 still held
      for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("rst_inc_after", int'(inc_pulse), 0);
      checkOutput("rst_level_after", int'(btn_level), 0);
      firstInc = 0;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (inc_pulse && firstInc == 0) firstInc = k;
      end
      checkOutput("rst_first_inc", firstInc, 7);
      for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b0);

      // Randomized segments of random length per button, with occasional reset
      tgt = '0; remain[0] = 0; remain[1] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 2; b++) begin
            if (remain[b] == 0) begin
               tgt[b]    = $urandom_range(0, 1);
               remain[b] = $urandom_range(1, 45);
            end
            remain[b]--;
         end
         applyStimulus($urandom_range(0, 299) == 0, tgt[0], tgt[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
